// File: rtl/ccm_host_pkg.sv
// Shared types and sizes for the crypto control unit host sequencer.
package ccm_host_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned WORDS   = 4;
    localparam int unsigned BLOCK_W = WORD_W * WORDS;
    localparam int unsigned IDX_W   = $clog2(WORDS);

    typedef logic [IDX_W-1:0] word_idx_t;

    // Packed block; element WORDS-1 holds the most significant word (word index 0).
    typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ARM,
        S_KEY_LD,
        S_KEY_RD,
        S_WAIT_IRQ,
        S_ACK,
        S_DATA_LD,
        S_DONE,
        S_WAIT_RES,
        S_COLLECT,
        S_RELEASE,
        S_RESP
    } state_t;

    // Map a bus word index (MSW first) onto the packed block element.
    function automatic word_idx_t msw_slot(input word_idx_t idx);
        return IDX_W'(WORDS - 1) - idx;
    endfunction

endpackage

// File: rtl/ccm_word_seq.sv
// Word counter plus MSW-first word select, shared by the key load, data load and result
// collection phases. The counter returns to word 0 whenever step is low.
module ccm_word_seq
    import ccm_host_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               step,
    input  logic [BLOCK_W-1:0] block,
    output logic [IDX_W-1:0]   idx,
    output logic               last_c,
    output logic [WORD_W-1:0]  word_c
);

    block_t    blk;
    word_idx_t idx_d;

    assign blk    = block;
    assign last_c = (idx == IDX_W'(WORDS - 1));

    // Next word index: advance while stepping, wrap to 0 at the end of the phase.
    always_comb begin
        idx_d = '0;
        if (step && !last_c) begin
            idx_d = idx + IDX_W'(1);
        end
    end

    // Word index register; drives the bus address directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else begin
            idx <= idx_d;
        end
    end

    // Word that goes on the bus next cycle, so the caller can register it.
    assign word_c = blk[msw_slot(idx_d)];

endmodule

// File: rtl/ccm_host_seq.sv
// Host-side initiator for the crypto control unit handshake: loads key and block, services
// the key-expansion interrupt, collects the result and returns it as a single response.
// Optional per-wait watchdog: define CCM_HOST_TIMEOUT_EN.
module ccm_host_seq
    import ccm_host_pkg::*;
`ifdef CCM_HOST_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
)
`endif
(
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_encrypt,
    input  logic [BLOCK_W-1:0] req_key,
    input  logic [BLOCK_W-1:0] req_data,
    output logic               enable,
    output logic               e_or_d,
    output logic               read,
    input  logic               irq,
    output logic               irq_resp,
    output logic               data_done,
    input  logic               ready,
    output logic [IDX_W-1:0]   bus_addr,
    output logic [WORD_W-1:0]  bus_wdata,
    output logic               bus_key_we,
    output logic               bus_data_we,
    output logic               res_re,
    input  logic [WORD_W-1:0]  res_rdata,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [BLOCK_W-1:0] resp_data,
    output logic               resp_err
);

    state_t       state_q, state_d;
    block_t       key_q, data_q, res_q;
    logic         tail_q, tail_d;
    logic         rd_pend_q;
    word_idx_t    rd_idx_q;
    logic         step, last_c, accept, timeout_c;
    logic [WORD_W-1:0]  word_c;
    logic [BLOCK_W-1:0] src_blk;

    assign accept    = req_valid && req_ready;
    assign src_blk   = (state_d == S_DATA_LD) ? data_q : key_q;
    assign resp_data = res_q;

    ccm_word_seq u_word_seq (
        .clk    (clk),
        .rst    (rst),
        .step   (step),
        .block  (src_blk),
        .idx    (bus_addr),
        .last_c (last_c),
        .word_c (word_c)
    );

`ifdef CCM_HOST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q;
    logic            wait_c;
    logic            err_q;

    assign wait_c    = state_q inside {S_ARM, S_WAIT_IRQ, S_WAIT_RES};
    assign timeout_c = wait_c && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign resp_err  = err_q;

    // Watchdog: counts cycles spent in the current wait state, reloads on any state change.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q <= '0;
        end else if (!wait_c || (state_d != state_q)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Abort flag reported with the response; cleared when a new job is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= 1'b0;
        end else if (timeout_c) begin
            err_q <= 1'b1;
        end
    end
`else
    assign timeout_c = 1'b0;
    assign resp_err  = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a watchdog expiry wins over progress in the same cycle.
    always_comb begin
        state_d = state_q;
        tail_d  = 1'b0;
        step    = 1'b0;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_ARM;
            S_ARM:      if (timeout_c) state_d = S_RELEASE;
                        else if (!ready) state_d = S_KEY_LD;
            S_KEY_LD: begin
                step = 1'b1;
                if (last_c) state_d = S_KEY_RD;
            end
            S_KEY_RD:   state_d = S_WAIT_IRQ;
            S_WAIT_IRQ: if (timeout_c) state_d = S_RELEASE;
                        else if (irq) state_d = S_ACK;
            S_ACK:      state_d = S_DATA_LD;
            S_DATA_LD: begin
                step = 1'b1;
                if (last_c) state_d = S_DONE;
            end
            S_DONE:     state_d = S_WAIT_RES;
            S_WAIT_RES: if (timeout_c) state_d = S_RELEASE;
                        else if (ready) state_d = S_COLLECT;
            S_COLLECT: begin
                // WORDS read cycles, then one tail cycle for the last returned word.
                if (tail_q) begin
                    state_d = S_RELEASE;
                end else begin
                    step   = 1'b1;
                    tail_d = last_c;
                end
            end
            S_RELEASE:  state_d = S_RESP;
            S_RESP:     if (resp_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Registered core/handshake outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready   <= 1'b1;
            enable      <= 1'b0;
            read        <= 1'b0;
            irq_resp    <= 1'b0;
            data_done   <= 1'b0;
            bus_key_we  <= 1'b0;
            bus_data_we <= 1'b0;
            bus_wdata   <= '0;
            res_re      <= 1'b0;
            resp_valid  <= 1'b0;
        end else begin
            req_ready   <= (state_d == S_IDLE);
            enable      <= !(state_d inside {S_IDLE, S_RELEASE, S_RESP});
            read        <= (state_d == S_KEY_RD);
            irq_resp    <= (state_d == S_ACK);
            data_done   <= (state_d == S_DONE);
            bus_key_we  <= (state_d == S_KEY_LD);
            bus_data_we <= (state_d == S_DATA_LD);
            bus_wdata   <= (state_d inside {S_KEY_LD, S_DATA_LD}) ? word_c : '0;
            res_re      <= (state_d == S_COLLECT) && !tail_d;
            resp_valid  <= (state_d == S_RESP);
        end
    end

    // Job capture on accept and result word capture one cycle after each res_re.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_q     <= '0;
            data_q    <= '0;
            res_q     <= '0;
            e_or_d    <= 1'b0;
            tail_q    <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
        end else begin
            tail_q    <= tail_d;
            rd_pend_q <= res_re;
            rd_idx_q  <= bus_addr;
            if (accept) begin
                key_q  <= req_key;
                data_q <= req_data;
                e_or_d <= req_encrypt;
                res_q  <= '0;
            end else if (rd_pend_q) begin
                res_q[msw_slot(rd_idx_q)] <= res_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ccm_host_seq.sv
// Directed bench for ccm_host_seq with a behavioural crypto core model.
// Define CCM_HOST_TIMEOUT_EN to also exercise the watchdog abort (TIMEOUT_CYCLES=16).
module tb_ccm_host_seq;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K3 = 128'h11111111222222223333333344444444;
    localparam logic [127:0] D3 = 128'h01010101020202020303030304040404;
    localparam logic [127:0] X3 = 128'h10101010202020203030303040404040;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_encrypt;
    logic [127:0] req_key;
    logic [127:0] req_data;
    logic         enable;
    logic         e_or_d;
    logic         read;
    logic         irq;
    logic         irq_resp;
    logic         data_done;
    logic         ready;
    logic [1:0]   bus_addr;
    logic [31:0]  bus_wdata;
    logic         bus_key_we;
    logic         bus_data_we;
    logic         res_re;
    logic [31:0]  res_rdata;
    logic         resp_valid;
    logic         resp_ready;
    logic [127:0] resp_data;
    logic         resp_err;

    int checks = 0;
    int errors = 0;

`ifdef CCM_HOST_TIMEOUT_EN
    ccm_host_seq #(.TIMEOUT_CYCLES(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_encrypt (req_encrypt),
        .req_key     (req_key),
        .req_data    (req_data),
        .enable      (enable),
        .e_or_d      (e_or_d),
        .read        (read),
        .irq         (irq),
        .irq_resp    (irq_resp),
        .data_done   (data_done),
        .ready       (ready),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_key_we  (bus_key_we),
        .bus_data_we (bus_data_we),
        .res_re      (res_re),
        .res_rdata   (res_rdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );
`else
    ccm_host_seq dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_encrypt (req_encrypt),
        .req_key     (req_key),
        .req_data    (req_data),
        .enable      (enable),
        .e_or_d      (e_or_d),
        .read        (read),
        .irq         (irq),
        .irq_resp    (irq_resp),
        .data_done   (data_done),
        .ready       (ready),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_key_we  (bus_key_we),
        .bus_data_we (bus_data_we),
        .res_re      (res_re),
        .res_rdata   (res_rdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_err    (resp_err)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model state and monitor counters
    logic [31:0]  kw [4];
    logic [31:0]  dw [4];
    logic [31:0]  res_w [4];
    logic [127:0] mk, md, mr;
    int  irq_delay = 3;
    int  arm_delay = 0;
    int  irq_tmr = 0;
    int  res_tmr = 0;
    int  arm_tmr = 0;
    bit  mbusy = 1'b0;
    bit  pend = 1'b0;
    logic [1:0] pend_addr = 2'd0;
    int  ncyc = 0;
    int  read_cnt = 0, ack_cnt = 0, read_cyc = 0, ack_cyc = 0, irq_cyc = 0, rel_cyc = 0;
    int  eod_bad = 0, early_key = 0;
    bit  irq_seen = 1'b0;
    logic exp_eod = 1'b1;

    initial begin
        ready     = 1'b1;
        irq       = 1'b0;
        res_rdata = 32'h0;
    end

    // Behavioural core: observe DUT outputs first, then update the core's own outputs.
    always @(negedge clk) begin
        ncyc++;
        if (read) begin read_cnt++; read_cyc = ncyc; end
        if (irq_resp) begin ack_cnt++; ack_cyc = ncyc; end
        if (irq && !irq_seen) begin irq_seen = 1'b1; irq_cyc = ncyc; end
        if (enable && (e_or_d !== exp_eod)) eod_bad++;
        if (bus_key_we && !mbusy) early_key++;
        if ((read_cyc > 0) && (rel_cyc == 0) && !enable && (ncyc > read_cyc)) rel_cyc = ncyc;

        if (rst || !enable) begin
            res_rdata = pend ? res_w[pend_addr] : 32'h0;
            pend      = 1'b0;
            ready     = 1'b1;
            irq       = 1'b0;
            mbusy     = 1'b0;
            irq_tmr   = 0;
            res_tmr   = 0;
            arm_tmr   = 0;
        end else begin
            res_rdata = pend ? res_w[pend_addr] : 32'h0;
            pend      = res_re;
            pend_addr = bus_addr;
            if (!mbusy) begin
                if (arm_tmr >= arm_delay) begin mbusy = 1'b1; ready = 1'b0; end
                else arm_tmr++;
            end
            if (bus_key_we) kw[bus_addr] = bus_wdata;
            if (bus_data_we) dw[bus_addr] = bus_wdata;
            if (read && (irq_delay > 0)) irq_tmr = irq_delay;
            else if (irq_tmr > 0) begin
                irq_tmr--;
                if (irq_tmr == 0) irq = 1'b1;
            end
            if (irq_resp) irq = 1'b0;
            if (data_done) begin
                mk = {kw[0], kw[1], kw[2], kw[3]};
                md = {dw[0], dw[1], dw[2], dw[3]};
                if (e_or_d && (mk == K1) && (md == P1)) mr = C1;
                else if (!e_or_d && (mk == K1) && (md == C1)) mr = P1;
                else mr = mk ^ md;
                for (int i = 0; i < 4; i++) res_w[i] = mr[127 - 32*i -: 32];
                res_tmr = 3;
            end else if (res_tmr > 0) begin
                res_tmr--;
                if (res_tmr == 0) ready = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        read_cnt = 0; ack_cnt = 0; read_cyc = 0; ack_cyc = 0; irq_cyc = 0; rel_cyc = 0;
        eod_bad = 0; early_key = 0; irq_seen = 1'b0;
    endtask

    task automatic submit(input logic [127:0] key, input logic [127:0] data, input logic enc);
        int n = 0;
        @(negedge clk);
        while (!req_ready && (n < 100)) begin @(negedge clk); n++; end
        chk("req_ready_before_submit", 128'(req_ready), 128'(1'b1));
        req_key = key; req_data = data; req_encrypt = enc; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int hold, input bit pulse,
                             output logic [127:0] rd, output logic err);
        int n = 0;
        while (!resp_valid && (n < 3000)) begin @(negedge clk); n++; end
        chk("resp_valid_seen", 128'(resp_valid), 128'(1'b1));
        chk("enable_low_in_resp", 128'(enable), 128'(1'b0));
        rd  = resp_data;
        err = resp_err;
        for (int i = 0; i < hold; i++) begin
            if (pulse) req_valid = i[0];
            @(negedge clk);
            chk("resp_valid_held", 128'(resp_valid), 128'(1'b1));
            chk("resp_data_held", resp_data, rd);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_valid_dropped", 128'(resp_valid), 128'(1'b0));
        chk("req_ready_after_resp", 128'(req_ready), 128'(1'b1));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [127:0] rd1, rd2;
        logic         er1, er2;
        int           n;

        rst = 1'b1; req_valid = 1'b0; req_encrypt = 1'b0;
        req_key = '0; req_data = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 128'(req_ready), 128'(1'b1));
        chk("rst_enable", 128'(enable), 128'(1'b0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(1'b0));
        chk("rst_resp_data", resp_data, 128'h0);
        chk("rst_e_or_d", 128'(e_or_d), 128'(1'b0));
        chk("rst_key_we", 128'(bus_key_we), 128'(1'b0));
        rst = 1'b0;

        // 1: encrypt FIPS-197 vector
        clr_mon(); exp_eod = 1'b1; irq_delay = 3; arm_delay = 0;
        submit(K1, P1, 1'b1);
        wait_resp(0, 1'b0, rd1, er1);
        chk("t1_resp_data", rd1, C1);
        chk("t1_resp_err", 128'(er1), 128'(1'b0));
        chk("t1_read_pulses", 128'(read_cnt), 128'(1));
        chk("t1_irq_resp_pulses", 128'(ack_cnt), 128'(1));
        chk("t1_key_w0", 128'(kw[0]), 128'h00010203);
        chk("t1_key_w1", 128'(kw[1]), 128'h04050607);
        chk("t1_key_w2", 128'(kw[2]), 128'h08090a0b);
        chk("t1_key_w3", 128'(kw[3]), 128'h0c0d0e0f);
        chk("t1_data_w0", 128'(dw[0]), 128'h00112233);
        chk("t1_eod_stable", 128'(eod_bad), 128'(0));

        // 2: decrypt with irq delayed 50 cycles after read
        clr_mon(); exp_eod = 1'b0; irq_delay = 50;
        submit(K1, C1, 1'b0);
        wait_resp(0, 1'b0, rd1, er1);
        chk("t2_resp_data", rd1, P1);
        chk("t2_irq_resp_pulses", 128'(ack_cnt), 128'(1));
        chk("t2_ack_after_read", 128'(ack_cyc - read_cyc), 128'(51));
        chk("t2_ack_with_irq", 128'(ack_cyc), 128'(irq_cyc));
        chk("t2_eod_stable", 128'(eod_bad), 128'(0));

        // 3: response held 20 cycles while req_valid pulses
        clr_mon(); exp_eod = 1'b1; irq_delay = 2;
        submit(K3, D3, 1'b1);
        wait_resp(20, 1'b1, rd1, er1);
        chk("t3_resp_data", rd1, X3);
        repeat (5) @(negedge clk);
        chk("t3_no_job_enable", 128'(enable), 128'(1'b0));
        chk("t3_no_job_ready", 128'(req_ready), 128'(1'b1));

        // 4: reset in DATA_LD after word 2
        clr_mon(); irq_delay = 3;
        submit(K1, P1, 1'b1);
        n = 0;
        while (!(bus_data_we && (bus_addr == 2'd2)) && (n < 500)) begin @(negedge clk); n++; end
        chk("t4_reached_word2", 128'(bus_data_we), 128'(1'b1));
        rst = 1'b1;
        #1;
        chk("t4_enable_drop", 128'(enable), 128'(1'b0));
        chk("t4_req_ready", 128'(req_ready), 128'(1'b1));
        chk("t4_data_we_drop", 128'(bus_data_we), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) n++;
        end
        chk("t4_no_resp", 128'(n), 128'(0));

`ifdef CCM_HOST_TIMEOUT_EN
        // 5: irq never arrives, watchdog aborts after 16 cycles in WAIT_IRQ
        clr_mon(); exp_eod = 1'b1; irq_delay = 0;
        submit(K1, P1, 1'b1);
        wait_resp(0, 1'b0, rd1, er1);
        chk("t5_resp_err", 128'(er1), 128'(1'b1));
        chk("t5_resp_data", rd1, 128'h0);
        chk("t5_enable_drop_cycle", 128'(rel_cyc - read_cyc), 128'(17));
        chk("t5_no_irq_resp", 128'(ack_cnt), 128'(0));
`endif

        // 6: back-to-back encrypt then decrypt, core slow to leave idle
        clr_mon(); exp_eod = 1'b1; irq_delay = 4; arm_delay = 4;
        submit(K1, P1, 1'b1);
        wait_resp(0, 1'b0, rd1, er1);
        exp_eod = 1'b0;
        submit(K1, C1, 1'b0);
        wait_resp(0, 1'b0, rd2, er2);
        chk("t6_first_result", rd1, C1);
        chk("t6_second_result", rd2, P1);
        chk("t6_second_err", 128'(er2), 128'(1'b0));
        chk("t6_key_before_core_busy", 128'(early_key), 128'(0));
        chk("t6_read_pulses", 128'(read_cnt), 128'(2));
        chk("t6_eod_stable", 128'(eod_bad), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
